// File: rtl/axi_10g_ethernet_0_user_pkg.sv
// Shared definitions for the user traffic generator and checker so both
// sides agree on the incrementing-byte pattern and tkeep handling.
package axi_10g_ethernet_0_user_pkg;

  localparam int PAT_BYTE_W = 8;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } chk_state_t;

  // Contiguous-from-LSB check; an all-zero keep has no hole and passes.
  function automatic logic keep_legal(input logic [7:0] tkeep);
    return ((tkeep & (tkeep + 8'd1)) == 8'd0);
  endfunction

  function automatic logic [3:0] keep_count(input logic [7:0] tkeep);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, tkeep[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/axi_10g_ethernet_0_user_checker_window.sv
// Fixed-length throughput window: free-running cycle counter plus a byte
// accumulator that is snapshotted into window_bytes at terminal count.
module axi_10g_ethernet_0_user_checker_window
  import axi_10g_ethernet_0_user_pkg::*;
#(
  parameter int WINDOW_CYCLES = 156_250_000
) (
  input  logic        s_aclk,
  input  logic        s_aresetn,
  input  logic        clear,
  input  logic [3:0]  byte_incr,
  output logic [63:0] window_bytes,
  output logic        window_valid
);

  localparam int CNT_W = $clog2(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0] TC = CNT_W'(WINDOW_CYCLES - 1);

  logic [CNT_W-1:0] cyc_cnt;
  logic [63:0]      acc;
  logic             tc;

  assign tc = (cyc_cnt == TC);

  always_ff @(posedge s_aclk) begin
    if (!s_aresetn) begin
      cyc_cnt      <= '0;
      acc          <= '0;
      window_bytes <= '0;
      window_valid <= 1'b0;
    end else begin
      window_valid <= tc;
      if (tc) begin
        cyc_cnt      <= '0;
        window_bytes <= acc + 64'(byte_incr);
        acc          <= '0;
      end else begin
        cyc_cnt <= cyc_cnt + CNT_W'(1);
        acc     <= clear ? 64'd0 : acc + 64'(byte_incr);
      end
    end
  end

endmodule

// File: rtl/axi_10g_ethernet_0_user_checker.sv
// Receive-side pattern checker: locks on the generator's incrementing-byte
// stream, counts bytes and error beats, and reports per-window throughput.
module axi_10g_ethernet_0_user_checker
  import axi_10g_ethernet_0_user_pkg::*;
#(
  parameter int WINDOW_CYCLES = 156_250_000,
  parameter int ERR_CNT_WIDTH = 32
) (
  input  logic                     s_aclk,
  input  logic                     s_aresetn,
  input  logic                     m_axis_tvalid,
  output logic                     m_axis_tready,
  input  logic [63:0]              m_axis_tdata,
  input  logic [7:0]               m_axis_tkeep,
  input  logic                     chk_enable,
  input  logic                     clear,
  output logic                     locked,
  output logic [63:0]              byte_count,
  output logic [ERR_CNT_WIDTH-1:0] error_count,
  output logic [63:0]              first_err_offset,
  output logic [63:0]              window_bytes,
  output logic                     window_valid
);

  chk_state_t            state;
  logic [PAT_BYTE_W-1:0] exp_byte;
  logic [PAT_BYTE_W-1:0] base;
  logic [PAT_BYTE_W-1:0] top_lane;
  logic [3:0]            n;
  logic [3:0]            byte_incr;
  logic                  legal;
  logic                  keep_nz;
  logic                  mismatch;
  logic                  accept;
  logic                  count_beat;
  logic                  err_event;

  // The locking beat is only checked for intra-beat consistency, so it
  // compares against its own lane 0.
  always_comb begin
    n        = keep_count(m_axis_tkeep);
    legal    = keep_legal(m_axis_tkeep);
    keep_nz  = |m_axis_tkeep;
    base     = (state == LOCKED) ? exp_byte : m_axis_tdata[PAT_BYTE_W-1:0];
    mismatch = 1'b0;
    top_lane = m_axis_tdata[PAT_BYTE_W-1:0];
    for (int i = 0; i < 8; i++) begin
      if (m_axis_tkeep[i]) begin
        if (m_axis_tdata[PAT_BYTE_W*i +: PAT_BYTE_W] != base + PAT_BYTE_W'(i))
          mismatch = 1'b1;
        top_lane = m_axis_tdata[PAT_BYTE_W*i +: PAT_BYTE_W];
      end
    end
    accept     = m_axis_tvalid && m_axis_tready;
    count_beat = accept && keep_nz && legal;
    err_event  = accept && keep_nz && (!legal || mismatch);
    byte_incr  = (count_beat && !clear) ? n : 4'd0;
  end

  // On a legal beat, match or not, the next expected byte is always the top
  // valid lane plus one; this is what makes a mismatch resync in one beat.
  always_ff @(posedge s_aclk) begin
    if (!s_aresetn) begin
      state            <= UNLOCKED;
      locked           <= 1'b0;
      exp_byte         <= '0;
      m_axis_tready    <= 1'b0;
      byte_count       <= '0;
      error_count      <= '0;
      first_err_offset <= '0;
    end else begin
      m_axis_tready <= chk_enable;
      if (clear) begin
        state            <= UNLOCKED;
        locked           <= 1'b0;
        exp_byte         <= '0;
        byte_count       <= '0;
        error_count      <= '0;
        first_err_offset <= '0;
      end else begin
        if (count_beat) begin
          state      <= LOCKED;
          locked     <= 1'b1;
          exp_byte   <= top_lane + PAT_BYTE_W'(1);
          byte_count <= byte_count + 64'(n);
        end
        if (err_event) begin
          if (error_count != '1)
            error_count <= error_count + ERR_CNT_WIDTH'(1);
          if (error_count == '0)
            first_err_offset <= byte_count;
        end
      end
    end
  end

  axi_10g_ethernet_0_user_checker_window #(
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_window (
    .s_aclk      (s_aclk),
    .s_aresetn   (s_aresetn),
    .clear       (clear),
    .byte_incr   (byte_incr),
    .window_bytes(window_bytes),
    .window_valid(window_valid)
  );

endmodule
